// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle between the operand stage and alu_mc.
//   master (requester): drives start, op, a, b; observes busy, done, result,
//                       result_hi and the cout/zero/set/overflow flags.
//   slave  (alu_mc):    the mirror image.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             cout;
    logic             zero;
    logic             set;
    logic             overflow;

    modport master (
        output start, op, a, b,
        input  busy, done, result, result_hi, cout, zero, set, overflow
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, result_hi, cout, zero, set, overflow
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU. AND/OR/ADD/SUB/SLT/SLL/SRA finish in one
// cycle; MUL is an unsigned shift-add multiplier taking WIDTH iterations.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (clears state and every output)
//   bus    alu_mc_if.slave: start/op/a/b in; busy/done/result/result_hi and
//          cout/zero/set/overflow out, all registered. WIDTH must be a power
//          of two between 8 and 64.
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    alu_mc_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;     // {partial product high half, remaining multiplier bits}
    logic [SHW-1:0]     cnt;

    logic               sub_c;
    logic [WIDTH-1:0]   b_eff_c;
    logic [WIDTH:0]     sum_c;
    logic               add_ovf_c;
    logic               add_set_c;
    logic [WIDTH-1:0]   res_c;
    logic               cout_c;
    logic               zero_c;
    logic               set_c;
    logic               ovf_c;
    logic [WIDTH:0]     add_hi_c;
    logic [2*WIDTH-1:0] acc_nxt_c;

    // Single-cycle datapath: shared adder for ADD/SUB/SLT plus logic and shifts.
    always_comb begin
        sub_c     = (bus.op == OP_SUB) || (bus.op == OP_SLT);
        b_eff_c   = sub_c ? ~bus.b : bus.b;
        sum_c     = {1'b0, bus.a} + {1'b0, b_eff_c} + {{WIDTH{1'b0}}, sub_c};
        add_ovf_c = (bus.a[WIDTH-1] == b_eff_c[WIDTH-1]) && (sum_c[WIDTH-1] != bus.a[WIDTH-1]);
        add_set_c = sum_c[WIDTH-1] ^ add_ovf_c;
        res_c     = '0;
        cout_c    = 1'b0;
        set_c     = 1'b0;
        ovf_c     = 1'b0;
        case (bus.op)
            OP_AND: res_c = bus.a & bus.b;
            OP_OR:  res_c = bus.a | bus.b;
            OP_ADD, OP_SUB: begin
                res_c  = sum_c[WIDTH-1:0];
                cout_c = sum_c[WIDTH];
                set_c  = add_set_c;
                ovf_c  = add_ovf_c;
            end
            OP_SLT: begin
                res_c  = WIDTH'(add_set_c);
                cout_c = sum_c[WIDTH];
                set_c  = add_set_c;
                ovf_c  = add_ovf_c;
            end
            OP_SLL: res_c = bus.a << bus.b[SHW-1:0];
            OP_SRA: res_c = $unsigned($signed(bus.a) >>> bus.b[SHW-1:0]);
            default: res_c = '0;
        endcase
        // SLT reports zero from the difference so either SUB or SLT serves beq.
        zero_c = (bus.op inside {OP_ADD, OP_SUB, OP_SLT}) ? (sum_c[WIDTH-1:0] == '0)
                                                          : (res_c == '0);
    end

    // One shift-add step; the WIDTH+1-bit upper sum keeps the carry before the shift.
    always_comb begin
        add_hi_c  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_nxt_c = {add_hi_c, acc[WIDTH-1:1]};
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            mcand         <= '0;
            acc           <= '0;
            cnt           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.result    <= '0;
            bus.result_hi <= '0;
            bus.cout      <= 1'b0;
            bus.zero      <= 1'b0;
            bus.set       <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.op == OP_MUL) begin
                            mcand    <= bus.a;
                            acc      <= {{WIDTH{1'b0}}, bus.b};
                            cnt      <= '0;
                            bus.busy <= 1'b1;
                            state    <= S_MUL;
                        end else begin
                            bus.result    <= res_c;
                            bus.result_hi <= '0;
                            bus.cout      <= cout_c;
                            bus.zero      <= zero_c;
                            bus.set       <= set_c;
                            bus.overflow  <= ovf_c;
                            bus.done      <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc <= acc_nxt_c;
                    cnt <= cnt + 1'b1;
                    // Final iteration publishes the product directly (no extra cycle).
                    if (cnt == SHW'(WIDTH - 1)) begin
                        state         <= S_IDLE;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        bus.result    <= acc_nxt_c[WIDTH-1:0];
                        bus.result_hi <= acc_nxt_c[2*WIDTH-1:WIDTH];
                        bus.zero      <= (acc_nxt_c == '0);
                        bus.cout      <= |acc_nxt_c[2*WIDTH-1:WIDTH];
                        bus.set       <= 1'b0;
                        bus.overflow  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
